// File: rtl/sl3_link_reset_sequencer.sv
// sl3_link_reset_sequencer
// Sequences PLL, TX and RX resets for one serial-lite lane group and reports
// link-up or permanent failure. Every wait phase is supervised by a watchdog
// timer; an expired wait forces a full re-reset, up to MAX_RETRIES attempts.
//
// Ports:
//   clk, srst        clock, synchronous active-high reset
//   link_enable      high requests bring-up, low forces IDLE
//   pll_locked       TX PLL lock (already synchronised to clk)
//   rx_cdr_locked    RX CDR lock-to-data (already synchronised)
//   rx_aligned       word alignment achieved (already synchronised)
//   pll_reset        TX PLL reset, active-high
//   tx_reset         TX PCS reset, active-high
//   rx_reset         RX PCS/CDR reset, active-high
//   link_up          link operational
//   link_fail        retries exhausted
//   retry_count      failed attempts since last IDLE or LINK_UP
//   state            current state encoding (debug)
module sl3_link_reset_sequencer #(
  parameter int unsigned TIMEOUT_BITS = 16,
  parameter int unsigned HOLD_BITS    = 4,
  parameter int unsigned MAX_RETRIES  = 3
) (
  input  logic       clk,
  input  logic       srst,
  input  logic       link_enable,
  input  logic       pll_locked,
  input  logic       rx_cdr_locked,
  input  logic       rx_aligned,
  output logic       pll_reset,
  output logic       tx_reset,
  output logic       rx_reset,
  output logic       link_up,
  output logic       link_fail,
  output logic [3:0] retry_count,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_PLL  = 3'd1,
    WAIT_PLL   = 3'd2,
    RELEASE    = 3'd3,
    WAIT_CDR   = 3'd4,
    WAIT_ALIGN = 3'd5,
    LINK_UP    = 3'd6,
    FAIL       = 3'd7
  } state_e;

  localparam logic [4:0] MAX_R5 = 5'(MAX_RETRIES);
  localparam logic [3:0] MAX_R4 = 4'(MAX_RETRIES);
  localparam logic [TIMEOUT_BITS:0] TIMER_ONE = (TIMEOUT_BITS+1)'(1);

  state_e                state_q, state_d;
  logic [TIMEOUT_BITS:0] timer_q, timer_d;
  logic [3:0]            retry_q, retry_d;
  logic                  pll_reset_q, pll_reset_d;
  logic                  tx_reset_q, tx_reset_d;
  logic                  rx_reset_q, rx_reset_d;
  logic                  link_up_q, link_up_d;
  logic                  link_fail_q, link_fail_d;

  logic hold_done, timeout, retry_path;

  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    retry_path = 1'b0;
    hold_done  = timer_q[HOLD_BITS];
    timeout    = timer_q[TIMEOUT_BITS];

    if (!link_enable) begin
      state_d = IDLE;
    end else begin
      // Success conditions are tested before failure conditions so that a
      // lock arriving on the timeout cycle still advances the sequence.
      unique case (state_q)
        IDLE:       state_d = RESET_PLL;
        RESET_PLL:  if (hold_done) state_d = WAIT_PLL;
        WAIT_PLL: begin
          if (pll_locked)   state_d = RELEASE;
          else if (timeout) retry_path = 1'b1;
        end
        RELEASE: begin
          if (hold_done)        state_d = WAIT_CDR;
          else if (!pll_locked) retry_path = 1'b1;
        end
        WAIT_CDR: begin
          if (rx_cdr_locked)                retry_path = 1'b0;
          else if (timeout || !pll_locked)  retry_path = 1'b1;
          if (rx_cdr_locked)                state_d = WAIT_ALIGN;
        end
        WAIT_ALIGN: begin
          if (rx_aligned && rx_cdr_locked) state_d = LINK_UP;
          else if (timeout || !rx_cdr_locked || !pll_locked) retry_path = 1'b1;
        end
        LINK_UP: begin
          if (!(pll_locked && rx_cdr_locked && rx_aligned)) state_d = RESET_PLL;
        end
        FAIL:       state_d = FAIL;
        default:    state_d = IDLE;
      endcase
    end

    if (retry_path) begin
      if ({1'b0, retry_q} + 5'd1 == MAX_R5) begin
        state_d = FAIL;
        retry_d = MAX_R4;
      end else begin
        state_d = RESET_PLL;
        retry_d = retry_q + 4'd1;
      end
    end

    if (state_d == IDLE || (state_d == LINK_UP && state_q != LINK_UP)) begin
      retry_d = '0;
    end

    if (state_d != state_q)  timer_d = '0;
    else if (timeout)        timer_d = timer_q;
    else                     timer_d = timer_q + TIMER_ONE;

    // Outputs decoded from the next state so they switch with state.
    pll_reset_d = (state_d == IDLE) || (state_d == RESET_PLL) || (state_d == FAIL);
    tx_reset_d  = pll_reset_d || (state_d == WAIT_PLL);
    rx_reset_d  = tx_reset_d  || (state_d == RELEASE);
    link_up_d   = (state_d == LINK_UP);
    link_fail_d = (state_d == FAIL);
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      tx_reset_q  <= 1'b1;
      rx_reset_q  <= 1'b1;
      link_up_q   <= 1'b0;
      link_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pll_reset_q <= pll_reset_d;
      tx_reset_q  <= tx_reset_d;
      rx_reset_q  <= rx_reset_d;
      link_up_q   <= link_up_d;
      link_fail_q <= link_fail_d;
    end
  end

  assign pll_reset   = pll_reset_q;
  assign tx_reset    = tx_reset_q;
  assign rx_reset    = rx_reset_q;
  assign link_up     = link_up_q;
  assign link_fail   = link_fail_q;
  assign retry_count = retry_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sl3_link_reset_sequencer.sv
// Bench for sl3_link_reset_sequencer with TIMEOUT_BITS=6, HOLD_BITS=3,
// MAX_RETRIES=2. A reference model tracks phase, cycles-in-phase and the
// attempt count; directed scenarios and a random soak compare against it.
module tb_sl3_link_reset_sequencer;

  localparam int TO   = 64;  // timeout dwell threshold (cycles in phase)
  localparam int HOLD = 8;   // reset hold threshold
  localparam int MR   = 2;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       link_enable = 1'b0;
  logic       pll_locked = 1'b0;
  logic       rx_cdr_locked = 1'b0;
  logic       rx_aligned = 1'b0;
  logic       pll_reset, tx_reset, rx_reset, link_up, link_fail;
  logic [3:0] retry_count;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  sl3_link_reset_sequencer #(
    .TIMEOUT_BITS(6),
    .HOLD_BITS   (3),
    .MAX_RETRIES (2)
  ) dut (
    .clk          (clk),
    .srst         (srst),
    .link_enable  (link_enable),
    .pll_locked   (pll_locked),
    .rx_cdr_locked(rx_cdr_locked),
    .rx_aligned   (rx_aligned),
    .pll_reset    (pll_reset),
    .tx_reset     (tx_reset),
    .rx_reset     (rx_reset),
    .link_up      (link_up),
    .link_fail    (link_fail),
    .retry_count  (retry_count),
    .state        (state)
  );

  always #5 clk = ~clk;

  // Reference model: phase number, cycles spent in the phase, failed attempts.
  int m_state = 0;
  int m_age   = 0;
  int m_retry = 0;

  always @(posedge clk) begin : model
    int  nxt;
    bit  fail_attempt;
    nxt = m_state;
    fail_attempt = 0;
    if (srst) begin
      m_state = 0; m_age = 0; m_retry = 0;
    end else begin
      if (!link_enable) nxt = 0;
      else if (m_state == 0) nxt = 1;
      else if (m_state == 1) begin if (m_age == HOLD) nxt = 2; end
      else if (m_state == 2) begin
        if (pll_locked) nxt = 3; else if (m_age >= TO) fail_attempt = 1;
      end
      else if (m_state == 3) begin
        if (m_age == HOLD) nxt = 4; else if (!pll_locked) fail_attempt = 1;
      end
      else if (m_state == 4) begin
        if (rx_cdr_locked) nxt = 5;
        else if (m_age >= TO || !pll_locked) fail_attempt = 1;
      end
      else if (m_state == 5) begin
        if (rx_aligned && rx_cdr_locked) nxt = 6;
        else if (m_age >= TO || !rx_cdr_locked || !pll_locked) fail_attempt = 1;
      end
      else if (m_state == 6) begin
        if (!(pll_locked && rx_cdr_locked && rx_aligned)) nxt = 1;
      end
      if (fail_attempt) begin
        if (m_retry + 1 == MR) begin nxt = 7; m_retry = MR; end
        else begin m_retry = m_retry + 1; nxt = 1; end
      end
      if (nxt == 0 || (nxt == 6 && m_state != 6)) m_retry = 0;
      if (nxt != m_state) m_age = 0;
      else if (m_age < TO) m_age = m_age + 1;
      m_state = nxt;
    end
  end

  function automatic logic [11:0] dut_vec();
    return {state, pll_reset, tx_reset, rx_reset, link_up, link_fail, retry_count};
  endfunction

  function automatic logic [11:0] exp_vec();
    bit p, t, r;
    p = (m_state == 0 || m_state == 1 || m_state == 7);
    t = p || m_state == 2;
    r = t || m_state == 3;
    return {3'(m_state), p, t, r, m_state == 6, m_state == 7, 4'(m_retry)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the model reaches the given phase; returns 0 on budget expiry.
  task automatic run_until(input int target, input int budget, output bit ok);
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      tick();
      if (m_state == target) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    srst = 1; link_enable = 0;
    tick(); tick();
    checks++;
    if (dut_vec() !== 12'({3'd0, 5'b11100, 4'd0}))
      begin errors++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 12'({3'd0, 5'b11100, 4'd0})); end
    srst = 0;
  endtask

  task automatic test_clean_bringup();
    int pll_cnt = 0, rel_cnt = 0;
    bit ok = 0;
    link_enable = 1;
    for (int c = 0; c < 300; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec())
        begin errors++; $display("FAIL bringup_cycle got=%h want=%h", dut_vec(), exp_vec()); end
      if (pll_reset && state != 3'd0) pll_cnt++;
      if (state == 3'd3) rel_cnt++;
      if (m_state == 2 && m_age == 4) pll_locked = 1;
      if (m_state == 4 && m_age == 4) rx_cdr_locked = 1;
      if (m_state == 5 && m_age == 4) rx_aligned = 1;
      if (m_state == 6) begin ok = 1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL bringup_timeout got=0 want=1"); end
    checks++;
    if (pll_cnt != 9) begin errors++; $display("FAIL pll_reset_hold got=%0d want=9", pll_cnt); end
    checks++;
    if (rel_cnt != 9) begin errors++; $display("FAIL release_dwell got=%0d want=9", rel_cnt); end
    checks++;
    if ({link_up, retry_count} !== 5'b1_0000)
      begin errors++; $display("FAIL bringup_up got=%b want=10000", {link_up, retry_count}); end
  endtask

  task automatic test_pll_never_locks();
    int dur[$];
    int cur = 0;
    bit ok = 0;
    link_enable = 0; pll_locked = 0; rx_cdr_locked = 0; rx_aligned = 0;
    tick();
    link_enable = 1;
    for (int c = 0; c < 400; c++) begin
      tick();
      checks++;
      if (dut_vec() !== exp_vec())
        begin errors++; $display("FAIL nolock_cycle got=%h want=%h", dut_vec(), exp_vec()); end
      if (state == 3'd2) cur++;
      else if (cur > 0) begin
        dur.push_back(cur); cur = 0;
        if (dur.size() == 1) begin
          checks++;
          if ({retry_count, pll_reset} !== 5'b0001_1)
            begin errors++; $display("FAIL first_retry got=%b want=00011", {retry_count, pll_reset}); end
        end
      end
      if (m_state == 7) begin ok = 1; break; end
    end
    checks++;
    if (!ok || dur.size() != 2) begin errors++; $display("FAIL nolock_visits got=%0d want=2", dur.size()); end
    foreach (dur[i]) begin
      checks++;
      if (dur[i] != 65) begin errors++; $display("FAIL wait_pll_dwell got=%0d want=65", dur[i]); end
    end
    checks++;
    if (dut_vec() !== 12'({3'd7, 5'b11101, 4'd2}))
      begin errors++; $display("FAIL fail_state got=%h want=%h", dut_vec(), 12'({3'd7, 5'b11101, 4'd2})); end
  endtask

  task automatic test_fail_recovery();
    bit ok;
    link_enable = 0;
    tick();
    checks++;
    if (dut_vec() !== 12'({3'd0, 5'b11100, 4'd0}))
      begin errors++; $display("FAIL recover_idle got=%h want=%h", dut_vec(), 12'({3'd0, 5'b11100, 4'd0})); end
    link_enable = 1; pll_locked = 1; rx_cdr_locked = 1; rx_aligned = 1;
    run_until(6, 100, ok);
    checks++;
    if (!ok || link_up !== 1'b1 || dut_vec() !== exp_vec())
      begin errors++; $display("FAIL recover_up got=%h want=%h", dut_vec(), exp_vec()); end
  endtask

  task automatic test_link_drop();
    bit ok;
    rx_aligned = 0;
    tick();
    rx_aligned = 1;
    checks++;
    if (dut_vec() !== 12'({3'd1, 5'b11100, 4'd0}))
      begin errors++; $display("FAIL drop_state got=%h want=%h", dut_vec(), 12'({3'd1, 5'b11100, 4'd0})); end
    run_until(6, 100, ok);
    checks++;
    if (!ok || {link_up, retry_count} !== 5'b1_0000)
      begin errors++; $display("FAIL drop_rebringup got=%b want=10000", {link_up, retry_count}); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    logic [3:0] r0;
    rx_cdr_locked = 0;
    run_until(4, 60, ok);
    checks++;
    if (!ok || state !== 3'd4) begin errors++; $display("FAIL reach_wait_cdr got=%0d want=4", state); end
    r0 = retry_count;
    for (int i = 0; i < 64; i++) tick();
    rx_cdr_locked = 1;
    tick();
    checks++;
    if ({state, retry_count} !== {3'd5, r0} || dut_vec() !== exp_vec())
      begin errors++; $display("FAIL simultaneous got=%h want=%h", {state, retry_count}, {3'd5, r0}); end
  endtask

  task automatic test_abort();
    bit ok;
    rx_cdr_locked = 0;
    run_until(4, 60, ok);
    srst = 1;
    tick();
    srst = 0;
    checks++;
    if (!ok || dut_vec() !== 12'({3'd0, 5'b11100, 4'd0}))
      begin errors++; $display("FAIL abort_srst got=%h want=%h", dut_vec(), 12'({3'd0, 5'b11100, 4'd0})); end
    pll_locked = 1;
    run_until(3, 60, ok);
    link_enable = 0;
    tick();
    checks++;
    if (!ok || dut_vec() !== 12'({3'd0, 5'b11100, 4'd0}))
      begin errors++; $display("FAIL abort_enable got=%h want=%h", dut_vec(), 12'({3'd0, 5'b11100, 4'd0})); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      srst          = ($urandom_range(0, 511) == 0);
      link_enable   = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 19) == 0) pll_locked    = ~pll_locked;
      if ($urandom_range(0, 19) == 0) rx_cdr_locked = ~rx_cdr_locked;
      if ($urandom_range(0, 15) == 0) rx_aligned    = ~rx_aligned;
      tick();
      checks++;
      if (dut_vec() !== exp_vec() || (link_up && link_fail))
        begin errors++; $display("FAIL random_cycle%0d got=%h want=%h", c, dut_vec(), exp_vec()); end
    end
    srst = 0;
  endtask

  initial begin
    test_reset();
    test_clean_bringup();
    test_pll_never_locks();
    test_fail_recovery();
    test_link_drop();
    test_simultaneous();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
